// File: rtl/ex_muldiv_pkg.sv
// Shared RV32M definitions: funct3/funct7 encodings, FSM state type and
// small decode helpers used by the multiply/divide unit.
package ex_muldiv_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_muldiv(input logic [6:0] funct7);
        return funct7 == FUNCT7_MULDIV;
    endfunction

    function automatic logic op1_signed(input logic [2:0] f3);
        case (f3)
            F3_MULH, F3_MULHSU, F3_DIV, F3_REM: return 1'b1;
            F3_MUL, F3_MULHU, F3_DIVU, F3_REMU: return 1'b0;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic op2_signed(input logic [2:0] f3);
        case (f3)
            F3_MULH, F3_DIV, F3_REM: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/div_core.sv
// Restoring unsigned divider retiring STEP quotient bits per step.
// Exposes the post-step values so the caller can capture the final result.
module div_core #(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient_next,
    output logic [XLEN-1:0] remainder_next
);

    logic [XLEN-1:0] quo_reg;
    logic [XLEN-1:0] rem_reg;
    logic [XLEN:0]   trial;
    logic [XLEN:0]   diff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_reg <= '0;
            rem_reg <= '0;
        end else if (load) begin
            quo_reg <= dividend;
            rem_reg <= '0;
        end else if (step) begin
            quo_reg <= quotient_next;
            rem_reg <= remainder_next;
        end
    end

    // Dividend bits shift out of the quotient register into the partial
    // remainder; diff[XLEN] set means the trial subtraction borrowed.
    always_comb begin
        quotient_next  = quo_reg;
        remainder_next = rem_reg;
        trial          = '0;
        diff           = '0;
        for (int i = 0; i < STEP; i++) begin
            trial = {remainder_next, quotient_next[XLEN-1]};
            diff  = trial - {1'b0, divisor};
            if (diff[XLEN]) begin
                remainder_next = trial[XLEN-1:0];
            end else begin
                remainder_next = diff[XLEN-1:0];
            end
            quotient_next = {quotient_next[XLEN-2:0], ~diff[XLEN]};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// RV32M execute unit: FSM, operand sign handling and multiplier, with the
// iterative divide delegated to div_core.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int STEP     = 1,
    parameter int MUL_ITER = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_wen_o,
    output logic            busy_o,
    output logic            hold_flag_o
);

    localparam int ITERS = XLEN / STEP;
    localparam int CNT_W = $clog2(ITERS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

    state_t            state_reg, state_next;
    logic [2:0]        funct3_reg;
    logic [4:0]        rd_pend_reg, rd_addr_reg;
    logic [XLEN-1:0]   abs2_reg, result_reg, result_next;
    logic              neg_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic              neg1_i, neg2_i, neg_i, div_zero_i, div_ovf_i, fast_i;
    logic [XLEN-1:0]   abs1_i, abs2_i;
    logic              accept, calc_last, load_result;
    logic [2:0]        sel_funct3;
    logic              sel_neg;
    logic [XLEN-1:0]   quo_next, rem_next, div_mag, div_signed;
    logic [2*XLEN-1:0] mul_prod, mul_signed;

    // Operand decode: everything downstream works on magnitudes.
    always_comb begin
        neg1_i     = op1_signed(funct3_i) & op1_i[XLEN-1];
        neg2_i     = op2_signed(funct3_i) & op2_i[XLEN-1];
        abs1_i     = neg1_i ? -op1_i : op1_i;
        abs2_i     = neg2_i ? -op2_i : op2_i;
        neg_i      = (funct3_i[2] & funct3_i[1]) ? neg1_i : (neg1_i ^ neg2_i);
        div_zero_i = funct3_i[2] && (op2_i == '0);
        div_ovf_i  = ((funct3_i == F3_DIV) || (funct3_i == F3_REM)) &&
                     (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&op2_i);
        fast_i     = funct3_i[2] ? (div_zero_i | div_ovf_i) : (MUL_ITER == 0);
    end

    assign accept      = start_i && !flush_i && ((state_reg == IDLE) || (state_reg == DONE));
    assign calc_last   = (state_reg == CALC) && (cnt_reg == CNT_LAST) && !flush_i;
    assign load_result = (accept && fast_i) || calc_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_i) state_next = fast_i ? DONE : CALC;
            CALC:    if (cnt_reg == CNT_LAST) state_next = DONE;
            DONE:    state_next = start_i ? (fast_i ? DONE : CALC) : IDLE;
            default: state_next = IDLE;
        endcase
        if (flush_i) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        busy_o      = (state_reg != IDLE);
        rd_wen_o    = (state_reg == DONE) && !flush_i;
        hold_flag_o = !rst && ((start_i && (state_reg == IDLE)) ||
                               (state_reg == CALC) ||
                               (start_i && (state_reg == DONE) && (state_next == CALC)));
    end

    div_core #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_div_core (
        .clk            (clk),
        .rst            (rst),
        .load           (accept),
        .step           (state_reg == CALC),
        .dividend       (abs1_i),
        .divisor        (abs2_reg),
        .quotient_next  (quo_next),
        .remainder_next (rem_next)
    );

    generate
        if (MUL_ITER == 0) begin : g_mul_comb
            assign mul_prod = {{XLEN{1'b0}}, abs1_i} * {{XLEN{1'b0}}, abs2_i};
        end else begin : g_mul_iter
            logic [XLEN-1:0]   mcand_reg;
            logic [2*XLEN-1:0] acc_reg, acc_step;
            logic [XLEN:0]     hi_sum;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mcand_reg <= '0;
                    acc_reg   <= '0;
                end else if (accept) begin
                    mcand_reg <= abs1_i;
                    acc_reg   <= {{XLEN{1'b0}}, abs2_i};
                end else if (state_reg == CALC) begin
                    acc_reg <= acc_step;
                end
            end

            // Multiplier sits in the low half and is consumed LSB first as
            // the partial product shifts down into its place.
            always_comb begin
                acc_step = acc_reg;
                hi_sum   = '0;
                for (int i = 0; i < STEP; i++) begin
                    hi_sum   = {1'b0, acc_step[2*XLEN-1:XLEN]} +
                               (acc_step[0] ? {1'b0, mcand_reg} : '0);
                    acc_step = {hi_sum, acc_step[XLEN-1:1]};
                end
            end

            assign mul_prod = acc_step;
        end
    endgenerate

    // Single-cycle ops format from the live inputs, multicycle ones from
    // the values latched at accept.
    always_comb begin
        sel_funct3  = accept ? funct3_i : funct3_reg;
        sel_neg     = accept ? neg_i : neg_reg;
        mul_signed  = sel_neg ? -mul_prod : mul_prod;
        div_mag     = sel_funct3[1] ? rem_next : quo_next;
        div_signed  = sel_neg ? -div_mag : div_mag;
        result_next = result_reg;
        if (accept && div_zero_i) begin
            result_next = funct3_i[1] ? op1_i : '1;
        end else if (accept && div_ovf_i) begin
            result_next = funct3_i[1] ? '0 : op1_i;
        end else if (sel_funct3[2]) begin
            result_next = div_signed;
        end else if (sel_funct3 == F3_MUL) begin
            result_next = mul_signed[XLEN-1:0];
        end else begin
            result_next = mul_signed[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            funct3_reg  <= '0;
            rd_pend_reg <= '0;
            abs2_reg    <= '0;
            neg_reg     <= 1'b0;
            cnt_reg     <= '0;
            result_reg  <= '0;
            rd_addr_reg <= '0;
        end else begin
            if (accept) begin
                funct3_reg  <= funct3_i;
                rd_pend_reg <= rd_addr_i;
                abs2_reg    <= abs2_i;
                neg_reg     <= neg_i;
                cnt_reg     <= '0;
            end else if (state_reg == CALC) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (load_result) begin
                result_reg  <= result_next;
                rd_addr_reg <= accept ? rd_addr_i : rd_pend_reg;
            end
        end
    end

    assign result_o  = result_reg;
    assign rd_addr_o = rd_addr_reg;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed corner cases plus random ops on three
// configurations, checked against an arithmetic reference model.
module tb_ex_muldiv;

    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] op1_i = '0;
    logic [31:0] op2_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        flush_i = 1'b0;

    logic [31:0] res_w  [NDUT];
    logic [4:0]  rda_w  [NDUT];
    logic        wen_w  [NDUT];
    logic        busy_w [NDUT];
    logic        hold_w [NDUT];

    int sel = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NDUT; gi++) begin : g_dut
            ex_muldiv #(
                .XLEN     (32),
                .STEP     (gi == 1 ? 4 : (gi == 2 ? 2 : 1)),
                .MUL_ITER (gi == 2 ? 1 : 0)
            ) dut (
                .clk         (clk),
                .rst         (rst),
                .start_i     (start_i),
                .funct3_i    (funct3_i),
                .op1_i       (op1_i),
                .op2_i       (op2_i),
                .rd_addr_i   (rd_addr_i),
                .flush_i     (flush_i),
                .result_o    (res_w[gi]),
                .rd_addr_o   (rda_w[gi]),
                .rd_wen_o    (wen_w[gi]),
                .busy_o      (busy_w[gi]),
                .hold_flag_o (hold_w[gi])
            );
        end
    endgenerate

    function automatic int step_of(input int s);
        return (s == 1) ? 4 : ((s == 2) ? 2 : 1);
    endfunction

    function automatic int mul_iter_of(input int s);
        return (s == 2) ? 1 : 0;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic following the RV32M definitions.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input int s, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        logic fast;
        if (f3[2]) begin
            fast = (b == 0) || ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        end else begin
            fast = (mul_iter_of(s) == 0);
        end
        return fast ? 1 : (32 / step_of(s)) + 1;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst     = 1'b1;
        start_i = 1'b1;
        flush_i = 1'b0;
        @(negedge clk);
        check_val("rst.busy", busy_w[sel], 0);
        check_val("rst.hold", hold_w[sel], 0);
        check_val("rst.wen", wen_w[sel], 0);
        check_val("rst.result", res_w[sel], 0);
        check_val("rst.rd", rda_w[sel], 0);
        @(posedge clk); #1;
        start_i = 1'b0;
        rst     = 1'b0;
    endtask

    // One op from IDLE: latency, result, destination, then return to IDLE.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input string tag);
        logic [31:0] exp_res;
        int          lat_exp;
        int          k;
        exp_res = ref_result(f3, a, b);
        lat_exp = exp_lat(sel, f3, a, b);
        k       = 0;
        @(posedge clk); #1;
        start_i   = 1'b1;
        funct3_i  = f3;
        op1_i     = a;
        op2_i     = b;
        rd_addr_i = rd;
        #1;
        check_val({tag, ".hold_req"}, hold_w[sel], 1);
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                start_i   = 1'b0;
                op1_i     = $urandom;
                op2_i     = $urandom;
                funct3_i  = 3'($urandom);
                rd_addr_i = 5'($urandom);
            end
            @(negedge clk);
            if (wen_w[sel]) begin
                k = i;
                break;
            end
        end
        $display("dut%0d op f3=%0d a=%08h b=%08h -> %08h (model %08h) rd=%0d lat=%0d",
                 sel, f3, a, b, res_w[sel], exp_res, rda_w[sel], k);
        check_val({tag, ".lat"}, k, lat_exp);
        check_val({tag, ".result"}, res_w[sel], exp_res);
        check_val({tag, ".rd"}, rda_w[sel], rd);
        @(posedge clk); #1;
        @(negedge clk);
        check_val({tag, ".wen_drop"}, wen_w[sel], 0);
        check_val({tag, ".busy_drop"}, busy_w[sel], 0);
        check_val({tag, ".held"}, res_w[sel], exp_res);
    endtask

    // DIVU 100/7 abandoned at t+10 by flush (use_rst=0) or reset (use_rst=1).
    task automatic kill_op(input bit use_rst, input string tag);
        int wen_seen;
        wen_seen = 0;
        @(posedge clk); #1;
        start_i   = 1'b1;
        funct3_i  = 3'd5;
        op1_i     = 32'd100;
        op2_i     = 32'd7;
        rd_addr_i = 5'd9;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 1) start_i = 1'b0;
            if (i == 10) begin
                if (use_rst) rst = 1'b1;
                else flush_i = 1'b1;
            end
            if (i == 11) begin
                rst     = 1'b0;
                flush_i = 1'b0;
            end
            @(negedge clk);
            if (wen_w[sel]) wen_seen++;
            if (i == 5) check_val({tag, ".busy_calc"}, busy_w[sel], 1);
            if (i == 11) check_val({tag, ".idle"}, busy_w[sel], 0);
        end
        check_val({tag, ".no_wen"}, wen_seen, 0);
    endtask

    // MUL 3x5 -> x5, then DIVU 15/4 -> x6 issued in the MUL's DONE cycle.
    task automatic back_to_back(input string tag);
        int iters;
        iters = 32 / step_of(sel);
        @(posedge clk); #1;
        start_i   = 1'b1;
        funct3_i  = 3'd0;
        op1_i     = 32'd3;
        op2_i     = 32'd5;
        rd_addr_i = 5'd5;
        @(posedge clk); #1;
        funct3_i  = 3'd5;
        op1_i     = 32'd15;
        op2_i     = 32'd4;
        rd_addr_i = 5'd6;
        @(negedge clk);
        check_val({tag, ".mul_wen"}, wen_w[sel], 1);
        check_val({tag, ".mul_result"}, res_w[sel], 32'd15);
        check_val({tag, ".mul_rd"}, rda_w[sel], 5);
        check_val({tag, ".hold_t1"}, hold_w[sel], 1);
        for (int i = 2; i <= iters + 3; i++) begin
            @(posedge clk); #1;
            if (i == 2) start_i = 1'b0;
            @(negedge clk);
            check_val({tag, ".hold"}, hold_w[sel], (i <= iters + 1) ? 1 : 0);
            check_val({tag, ".wen"}, wen_w[sel], (i == iters + 2) ? 1 : 0);
            if (i == iters + 2) begin
                check_val({tag, ".div_result"}, res_w[sel], 32'd3);
                check_val({tag, ".div_rd"}, rda_w[sel], 6);
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        sel = 0;
        do_reset();
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd1, "div_neg");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd2, "rem_neg");
        run_op(3'd5, 32'h1234_5678, 32'd0, 5'd3, "divu_zero");
        run_op(3'd7, 32'h1234_5678, 32'd0, 5'd4, "remu_zero");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, "rem_ovf");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd7, "mulh");
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8, "mulhsu");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, "mulhu");
        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, "mul");
        kill_op(1'b0, "flush");
        kill_op(1'b1, "rst_mid");
        run_op(3'd5, 32'd100, 32'd7, 5'd11, "after_rst");
        back_to_back("b2b_s1");
        sel = 1;
        do_reset();
        back_to_back("b2b_s4");
        for (int s = 0; s < NDUT; s++) begin
            sel = s;
            do_reset();
            for (int n = 0; n < 30; n++) begin
                run_op(3'($urandom), pick_operand(), pick_operand(), 5'($urandom), "rand");
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
